// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream into instruction memory,
// holds the CPU in reset until the zero terminator is written, then counts run cycles.
module imem_loader #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RST_HOLD   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  input  logic              end_program,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  cycle_count
);

  // RST_HOLD is expected to be at least 1.
  localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(RST_HOLD - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(IMEM_DEPTH - 1);

  typedef enum logic [2:0] {StLoad, StRelease, StRun, StDone, StError} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       full_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StLoad;
      byte_idx_q   <= 2'd0;
      word_q       <= 24'd0;
      word_ptr_q   <= '0;
      hold_q       <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      word_ptr_q   <= word_ptr_d;
      hold_q       <= hold_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    word_ptr_d   = word_ptr_q;
    hold_d       = hold_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    count_d      = count_q;
    full_word    = {in_data, word_q};

    unique case (state_q)
      StLoad: begin
        if (in_valid && in_ready_q) begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            default: begin
              imem_we_d    = 1'b1;
              imem_addr_d  = word_ptr_q;
              imem_wdata_d = full_word;
              word_ptr_d   = word_ptr_q + 1'b1;
              // The terminator is written even in the last slot, and wins over overflow.
              if (full_word == 32'd0) begin
                state_d = StRelease;
              end else if (word_ptr_q == LastAddr) begin
                state_d = StError;
              end
            end
          endcase
        end
      end
      StRelease: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun: begin
        if (end_program) begin
          state_d = StDone;
        end else if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
      end
      StDone, StError: ;
      default: state_d = StLoad;
    endcase

    // Flags follow the next state so every output is a plain register.
    in_ready_d  = (state_d == StLoad);
    cpu_reset_d = (state_d != StRun) && (state_d != StDone);
    done_d      = (state_d == StDone);
    err_d       = (state_d == StError);
  end

  assign in_ready    = in_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign done        = done_q;
  assign err         = err_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level program model predicts memory writes,
// release timing, run count (saturating) and overflow; a monitor checks every write.
module tb_imem_loader;

  localparam int unsigned Depth   = 4;
  localparam int unsigned AddrW   = 8;
  localparam int unsigned CntW    = 4;
  localparam int unsigned RstHold = 2;
  localparam int unsigned CntMax  = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             in_valid = 1'b0;
  logic             end_program = 1'b0;
  logic             in_ready;
  logic             imem_we;
  logic [AddrW-1:0] imem_addr;
  logic [31:0]      imem_wdata;
  logic             cpu_reset;
  logic             done;
  logic             err;
  logic [CntW-1:0]  cycle_count;

  always #5 clk = ~clk;

  imem_loader #(
    .IMEM_DEPTH(Depth),
    .ADDR_W    (AddrW),
    .CNT_W     (CntW),
    .RST_HOLD  (RstHold)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .end_program(end_program),
    .done       (done),
    .err        (err),
    .cycle_count(cycle_count)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [39:0] exp_q[$];   // {addr, data} of each expected write, in order
  logic        we_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops one expected write.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        check("write", 64'({imem_addr, imem_wdata}), 64'(exp_q.pop_front()));
        check("we_single_cycle", 64'(we_prev), 64'd0);
      end
    end
    we_prev = imem_we;
  end

  // Reference: split the byte list into LE words; returns 1 on terminator, 2 on overflow.
  function automatic int model(input logic [7:0] prog[$]);
    int addr = 0;
    for (int i = 0; i + 3 < prog.size(); i += 4) begin
      logic [31:0] w;
      w = {prog[i+3], prog[i+2], prog[i+1], prog[i]};
      exp_q.push_back({8'(addr), w});
      if (w == 32'd0) return 1;
      if (addr == Depth - 1) return 2;
      addr++;
    end
    return 0;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    end_program = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_outputs", 64'({imem_we, cpu_reset, done, err, cycle_count}), 64'({4'b0100, 4'd0}));
    check("rst_addr_data", 64'({imem_addr, imem_wdata}), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_hold_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int t;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_data = 8'($urandom);
      if (noise) end_program = 1'($urandom);
      @(negedge clk);
    end
    in_data = b;
    in_valid = 1'b1;
    if (noise) end_program = 1'($urandom);
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got in_ready 0 for 20 cycles, expected 1");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_program(input logic [7:0] prog[$], input int maxgap, input bit rnd_gap,
                              input bit noise);
    for (int i = 0; i < prog.size(); i++) begin
      int gap;
      gap = rnd_gap ? int'($urandom_range(0, maxgap)) : maxgap;
      send_byte(prog[i], gap, noise);
      if (i % 4 == 3) begin
        check("we_after_word", 64'({imem_we, imem_addr}), 64'({1'b1, 8'(i / 4)}));
      end
    end
    end_program = 1'b0;
  endtask

  task automatic run_program(input logic [7:0] prog[$], input int maxgap, input bit rnd_gap,
                             input bit noise, input int run_len);
    int outcome;
    int exp_cnt;
    apply_reset();
    outcome = model(prog);
    send_program(prog, maxgap, rnd_gap, noise);
    exp_cnt = (run_len > int'(CntMax)) ? int'(CntMax) : run_len;
    if (outcome == 1) begin
      check("term_ready_low", 64'({in_ready, cpu_reset}), 64'(2'b01));
      @(negedge clk);
      check("release_hold", 64'(cpu_reset), 64'd1);
      @(negedge clk);
      check("release_fall", 64'({cpu_reset, done, cycle_count}), 64'd0);
      repeat (run_len) @(negedge clk);
      check("count_running", 64'({done, cycle_count}), 64'(exp_cnt));
      end_program = 1'b1;
      @(negedge clk);
      end_program = 1'b0;
      check("done_count", 64'({done, cycle_count}), 64'({1'b1, 4'(exp_cnt)}));
      for (int i = 0; i < 10; i++) begin
        end_program = 1'($urandom);
        in_valid = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      end_program = 1'b0;
      check("done_stable", 64'({done, err, cpu_reset, in_ready, cycle_count}),
            64'({4'b1000, 4'(exp_cnt)}));
    end else if (outcome == 2) begin
      check("overflow_flags", 64'({err, in_ready, cpu_reset, done}), 64'(4'b1010));
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        in_data = 8'($urandom);
        end_program = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      end_program = 1'b0;
      check("overflow_stable", 64'({err, in_ready, cpu_reset, done}), 64'(4'b1010));
    end
    check("writes_pending", 64'(exp_q.size()), 64'd0);
  endtask

  logic [7:0] basic[$];
  logic [7:0] prog[$];

  initial begin
    int nw;
    logic [31:0] w;
    basic = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00};

    run_program(basic, 0, 1'b0, 1'b0, 7);    // basic load + run count
    run_program(basic, 3, 1'b0, 1'b1, 7);    // gapped, end_program noise while loading
    run_program(basic, 0, 1'b0, 1'b0, 20);   // saturation at 15

    prog = {};
    for (int i = 0; i < 16; i++) prog.push_back(8'(i + 1));
    run_program(prog, 0, 1'b0, 1'b0, 0);     // overflow

    // Reset mid-load: one word plus two bytes, then the basic stream from address 0.
    apply_reset();
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    void'(model(prog));
    send_program(prog, 0, 1'b0, 1'b0);
    check("partial_writes", 64'(exp_q.size()), 64'd0);
    run_program(basic, 0, 1'b0, 1'b0, 3);

    for (int it = 0; it < 10; it++) begin
      prog = {};
      nw = int'($urandom_range(0, 4));
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) w[8*b +: 8] = 8'd0;
        if (w == 32'd0) w = 32'd1;
        for (int b = 0; b < 4; b++) prog.push_back(w[8*b +: 8]);
      end
      if (nw < 4) for (int b = 0; b < 4; b++) prog.push_back(8'd0);
      run_program(prog, 3, 1'b1, 1'b1, int'($urandom_range(0, 20)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time front end for `cpu_pipelined`. It accepts a byte stream carrying a program, assembles little-endian 32-bit instruction words, and writes them into instruction memory through a dedicated write port. While loading, it holds the CPU in reset. Once the all-zero terminator word has been written, it releases the CPU and counts run cycles until the CPU raises `end_program`.

## Interface

Parameters:
- `IMEM_DEPTH`, 256: instruction memory depth in words.
- `ADDR_W`, 8: word address width; `2**ADDR_W >= IMEM_DEPTH`.
- `CNT_W`, 32: cycle counter width.
- `RST_HOLD`, 2: cycles `cpu_reset` stays high after the terminator write.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `in_data`  in  8: program byte.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `imem_we`  out  1: instruction memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W: word address of the write.
- `imem_wdata`  out  32: assembled instruction word.
- `cpu_reset`  out  1: active-high reset to `cpu_pipelined`.
- `end_program`  in  1: CPU halt indication.
- `done`  out  1: program finished; `cycle_count` is final.
- `err`  out  1: memory filled without a terminator.
- `cycle_count`  out  CNT_W: CPU run cycles.

## Operation

- States: LOAD, RELEASE, RUN, DONE, ERROR.
- Reset (async, `reset`=0) forces:
  - state LOAD; `byte_idx`=0; `word_ptr`=0; hold counter 0;
  - `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0;
  - `cpu_reset`=1, `done`=0, `err`=0, `cycle_count`=0.
- `in_ready` = 1 only in LOAD; it is 1 from the first cycle after reset release.
- LOAD:
  - A byte is accepted on each rising edge with `in_valid & in_ready`.
  - Byte k (k=0..3) goes to word bits [8k+7:8k]. `byte_idx` wraps 3->0.
  - On acceptance of byte 3, the assembled word is registered onto `imem_wdata`, `imem_addr`=`word_ptr`, `imem_we`=1 for exactly one cycle; `word_ptr`++.
  - If the word is 0x00000000, it is still written (the CPU needs the terminator) and the state goes to RELEASE on the same edge.
  - Else if `word_ptr` was `IMEM_DEPTH`-1, the word is written and the state goes to ERROR.
- RELEASE: `cpu_reset` stays 1 for `RST_HOLD` cycles, then drops to 0 on entry to RUN.
- RUN:
  - `cpu_reset`=0.
  - On each edge with `end_program`=0, `cycle_count`++ (saturates at all-ones, no wrap).
  - On an edge with `end_program`=1, the state goes to DONE and the count is not incremented.
- DONE: `done`=1; `cpu_reset` stays 0; count frozen; in_data ignored. Only reset leaves this state.
- ERROR: `err`=1; `cpu_reset`=1; `in_ready`=0. Only reset leaves this state.
- `end_program` is ignored outside RUN.
- `in_valid` is ignored when `in_ready`=0; no bytes are buffered.
- Reset asserted mid-load discards partial bytes. Memory contents already written are not cleared. Loading restarts at address 0.

## Timing

- Byte 3 accepted at edge N -> `imem_we`=1 during cycle N..N+1, low after edge N+1.
- Back-to-back words: byte stream at 1 byte/cycle gives a write every 4 cycles; no stall.
- Terminator accepted at edge N:
  - state is RELEASE and `in_ready`=0 after edge N;
  - `cpu_reset` falls after edge N+`RST_HOLD`;
  - first counted edge is N+`RST_HOLD`+1.
- `done` rises after the edge that samples `end_program`=1. `cycle_count` = number of RUN edges with `end_program`=0.
- All outputs are registered; no combinational path from `in_valid` or `end_program` to any output.

## Test plan

- **Basic load:** bytes 93 00 10 00, 13 01 20 00, 00 00 00 00 at 1/cycle -> writes addr0=0x00100093, addr1=0x00200113, addr2=0x00000000, each `imem_we` one cycle; `cpu_reset` falls 2 cycles after the terminator is accepted.
- **Gapped stream:** same bytes with `in_valid` low for 3 cycles between every byte -> identical writes and addresses; no extra or dropped bytes.
- **Run count:** after release, hold `end_program`=0 for 7 cycles, then 1 -> `cycle_count`=7, `done`=1, count stable for 10 further cycles; `end_program` pulsed during LOAD has no effect.
- **Overflow:** `IMEM_DEPTH`=4, feed 4 non-zero words -> 4 writes at addr 0..3, then `err`=1, `in_ready`=0, `cpu_reset` stays 1, `done`=0.
- **Reset mid-load:** assert `reset` after 6 bytes (one word plus 2 bytes), release, then send the basic load stream -> first write lands at addr0 with value 0x00100093; outputs at reset values during reset.
- **Saturation:** `CNT_W`=4, `end_program`=0 for 20 cycles, then 1 -> `cycle_count`=15.
